pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, rising-edge clock.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-003 SHALL have port ihit, input, 1, instruction memory returned data this cycle.
REQ-004 SHALL have port dhit, input, 1, data memory completed request this cycle.
REQ-005 SHALL have ports dmemr_mem and dmemw_mem, input, 1 each, load or store pending in MEM.
REQ-006 SHALL have ports branch_mem, zero_mem, jal_mem, jalr_mem and halt_mem, input, 1 each, MEM-stage control.
REQ-007 SHALL have ports dmemr_exe (input, 1), rd_exe (input, 5), rs1_dec (input, 5) and rs2_dec (input, 5), for load-use detection.
REQ-008 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 each, per-latch advance enables.
REQ-009 SHALL have ports ifid_flush, idex_flush and exmem_flush, output, 1 each, per-latch bubble inserts, honoured only with the matching enable.
REQ-010 SHALL have ports pc_redirect (output, 1, select MEM target as next PC), dmem_clr (output, 1, drop dmemr_mem/dmemw_mem in EX/MEM) and halted (output, 1).
REQ-011 SHALL have ports stall_cnt and flush_cnt, output, 16 each, saturating performance counters.

Function
REQ-012 SHALL implement FSM states RUN, MEMWAIT and HALT.
REQ-013 SHALL hold internal flag mem_done, set when dhit=1 and advance=0, cleared when advance=1.
REQ-014 SHALL define mem_req = (dmemr_mem | dmemw_mem) & !mem_done.
REQ-015 SHALL define advance = ihit & (!mem_req | dhit), evaluated combinationally.
REQ-016 SHALL assert dmem_clr combinationally when dhit=1 and advance=0.
REQ-017 SHALL, in RUN or MEMWAIT with advance=0, drive all five enables to 0 and all flushes to 0.
REQ-018 SHALL transition RUN->MEMWAIT when mem_req=1 and dhit=0, and MEMWAIT->RUN on the cycle advance=1.
REQ-019 SHALL define taken = (branch_mem & zero_mem) | jal_mem | jalr_mem.
REQ-020 SHALL, with advance=1 and taken=1, drive all enables to 1, pc_redirect=1, and ifid_flush, idex_flush and exmem_flush to 1.
REQ-021 SHALL define loaduse = dmemr_exe & (rd_exe!=0) & ((rd_exe==rs1_dec) | (rd_exe==rs2_dec)).
REQ-022 SHALL, with advance=1, taken=0 and loaduse=1, drive pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1 and memwb_en=1.
REQ-023 SHALL, with advance=1, taken=0 and loaduse=0, drive all enables to 1 and all flushes to 0.
REQ-024 SHALL apply priority halt > memory/fetch wait > redirect > load-use; taken overrides loaduse in the same cycle.
REQ-025 SHALL, with halt_mem=1 and advance=1, drive memwb_en=1, drive all other enables to 0, and enter HALT next cycle.
REQ-026 SHALL, in HALT, hold all enables, flushes, pc_redirect and dmem_clr at 0 and halted=1, leaving HALT only on RST.
REQ-027 SHALL increment stall_cnt each cycle not in HALT where advance=0 or the load-use bubble is inserted, saturating at 0xFFFF.
REQ-028 SHALL increment flush_cnt on each cycle REQ-020 applies, saturating at 0xFFFF.
REQ-029 SHALL make all outputs other than counters and halted combinational from state and inputs, with zero-cycle latency.

Reset
REQ-030 SHALL, on RST=1 at a rising edge, enter RUN, clear mem_done, stall_cnt and flush_cnt to 0 and halted to 0, including when reset arrives mid-MEMWAIT or in HALT.
REQ-031 SHALL, while RST=1, drive all enables, flushes, pc_redirect and dmem_clr to 0.

Verification
REQ-032 SHALL cover this scenario: ihit=1, dmemr_mem=1, dhit=0 for 3 cycles then 1 -> enables 0 for 3 cycles in MEMWAIT, then all 1, RUN, stall_cnt=3.
REQ-033 SHALL cover this scenario: dhit=1 with ihit=0, then ihit=1 two cycles later -> dmem_clr=1 on the first cycle, no re-wait, advance on the ihit cycle, mem_done cleared.
REQ-034 SHALL cover this scenario: dmemr_exe=1, rd_exe=5, rs2_dec=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, stall_cnt+1; with rd_exe=0 -> no stall.
REQ-035 SHALL cover this scenario: branch_mem=1, zero_mem=1, loaduse=1, ihit=1 -> pc_redirect=1, three flushes=1, pc_en=1, flush_cnt+1.
REQ-036 SHALL cover this scenario: halt_mem=1, ihit=1 -> memwb_en=1 only, then halted=1 and all enables 0 indefinitely; RST=1 -> RUN, counters 0.
REQ-037 SHALL cover this scenario: stall_cnt preloaded near 0xFFFF by a long stall -> holds at 0xFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-latch enables/flushes for a 5-stage core.
// Handles memory/fetch waits, MEM-stage redirects, load-use bubbles and halt,
// and keeps saturating stall/flush performance counters.
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmemr_mem,
  input  logic        dmemw_mem,
  input  logic        branch_mem,
  input  logic        zero_mem,
  input  logic        jal_mem,
  input  logic        jalr_mem,
  input  logic        halt_mem,
  input  logic        dmemr_exe,
  input  logic [4:0]  rd_exe,
  input  logic [4:0]  rs1_dec,
  input  logic [4:0]  rs2_dec,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        pc_redirect,
  output logic        dmem_clr,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  state_t state;
  logic   mem_done;   // data access already completed while the pipe was held

  logic mem_req, advance, taken, loaduse;
  logic active, halt_go, redirect, bubble, stall_evt;

  assign mem_req  = (dmemr_mem | dmemw_mem) & ~mem_done;
  assign advance  = ihit & (~mem_req | dhit);
  assign taken    = (branch_mem & zero_mem) | jal_mem | jalr_mem;
  assign loaduse  = dmemr_exe & (rd_exe != 5'd0) &
                    ((rd_exe == rs1_dec) | (rd_exe == rs2_dec));

  // Priority: halt > wait > redirect > load-use
  assign active    = ~RST & (state != HALT);
  assign halt_go   = active & advance & halt_mem;
  assign redirect  = active & advance & ~halt_mem & taken;
  assign bubble    = active & advance & ~halt_mem & ~taken & loaduse;
  assign stall_evt = active & (~advance | bubble);

  // Zero-latency enable/flush decode from state and current inputs
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_redirect = 1'b0;
    dmem_clr    = 1'b0;
    if (active) begin
      // data finished but pipe can't move: drop the request so it isn't replayed
      dmem_clr = dhit & ~advance;
      if (advance) begin
        if (halt_mem) begin
          memwb_en = 1'b1;
        end else if (taken) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
          pc_redirect = 1'b1;
        end else if (loaduse) begin
          {idex_en, exmem_en, memwb_en} = 3'b111;
          idex_flush = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
    end
  end

  // State, completion flag, halt flag and saturating counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      mem_done  <= 1'b0;
      halted    <= 1'b0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (state != HALT) begin
        if (advance)   mem_done <= 1'b0;
        else if (dhit) mem_done <= 1'b1;
      end
      case (state)
        RUN: begin
          if (halt_go)               state <= HALT;
          else if (mem_req & ~dhit)  state <= MEMWAIT;
        end
        MEMWAIT: begin
          if (halt_go)      state <= HALT;
          else if (advance) state <= RUN;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
      if (halt_go) halted <= 1'b1;
      if (stall_evt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (redirect  && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule
